// File: rtl/axi4_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_wr_pkg
//  Description : Shared types and helpers for the AXI4 write-burst tracker.
//                Provides the default AWLEN width, the AWLEN type and a
//                helper that sizes an occupancy counter for a given depth.
//  Revision    : 1.0  initial release
// ============================================================================
package axi4_wr_pkg;

    localparam int c_LEN_W_DEF = 8;

    typedef logic [c_LEN_W_DEF-1:0] axi_len_t;

    // Width needed to hold the values 0..depth inclusive.
    function automatic int OCC_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_wr_burst_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_wr_burst_tracker_if
//  Description : Handshake/control bundle between the AXI4 write path and the
//                burst tracker. The master side drives upstream AW/W controls,
//                downstream ready signals, master WLAST and error clear; the
//                slave side (the tracker) returns gated handshakes, the
//                regenerated WLAST, outstanding count and sticky error.
//  Ports       : io_awvalid/io_awready/io_awlen, io_wvalid/io_wready/io_wlast,
//                io_err_clr (into tracker); io_awvalid_o/io_awready_o,
//                io_wvalid_o/io_wready_o/io_wlast_o, io_outstanding,
//                io_err_wlast (out of tracker)
//  Revision    : 1.0  initial release
// ============================================================================
interface axi4_wr_burst_tracker_if #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
);
    import axi4_wr_pkg::*;

    localparam int c_OCC_W = OCC_W(DEPTH);

    logic               io_awvalid;
    logic               io_awready;
    logic [LEN_W-1:0]   io_awlen;
    logic               io_wvalid;
    logic               io_wready;
    logic               io_wlast;
    logic               io_err_clr;

    logic               io_awvalid_o;
    logic               io_awready_o;
    logic               io_wvalid_o;
    logic               io_wready_o;
    logic               io_wlast_o;
    logic [c_OCC_W-1:0] io_outstanding;
    logic               io_err_wlast;

    modport master (
        output io_awvalid, io_awready, io_awlen,
        output io_wvalid, io_wready, io_wlast, io_err_clr,
        input  io_awvalid_o, io_awready_o,
        input  io_wvalid_o, io_wready_o, io_wlast_o,
        input  io_outstanding, io_err_wlast
    );

    modport slave (
        input  io_awvalid, io_awready, io_awlen,
        input  io_wvalid, io_wready, io_wlast, io_err_clr,
        output io_awvalid_o, io_awready_o,
        output io_wvalid_o, io_wready_o, io_wlast_o,
        output io_outstanding, io_err_wlast
    );

endinterface
`default_nettype wire

// File: rtl/axi4_len_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_len_fifo
//  Description : Synchronous DEPTH x LEN_W FIFO holding queued AWLEN values.
//                Pointers carry one extra wrap bit to separate full from
//                empty. Full and not-empty flags are registered.
//  Ports       : clk, rst (async, active-high), i_wr, i_din, i_rd,
//                o_full, o_nempty, o_head, o_count
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_len_fifo
    import axi4_wr_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_wr,
    input  wire logic [LEN_W-1:0]         i_din,
    input  wire logic                     i_rd,
    output logic                          o_full,
    output logic                          o_nempty,
    output logic [LEN_W-1:0]              o_head,
    output logic [OCC_W(DEPTH)-1:0]       o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [LEN_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             r_full;
    logic             r_nempty;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [c_AW:0]    w_wr_ptr_nxt;
    logic [c_AW:0]    w_rd_ptr_nxt;
    logic             w_full_nxt;
    logic             w_nempty_nxt;

    // A write into a full FIFO is accepted only when the head is leaving in
    // the same cycle; the freed slot is the one being written.
    assign w_wr_en      = i_wr & (~r_full | i_rd);
    assign w_rd_en      = i_rd & r_nempty;

    assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, w_wr_en};
    assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, w_rd_en};

    assign w_full_nxt   = (w_wr_ptr_nxt[c_AW] != w_rd_ptr_nxt[c_AW]) &&
                          (w_wr_ptr_nxt[c_AW-1:0] == w_rd_ptr_nxt[c_AW-1:0]);
    assign w_nempty_nxt = (w_wr_ptr_nxt != w_rd_ptr_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_nempty <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= w_full_nxt;
            r_nempty <= w_nempty_nxt;
        end
    end

    // Storage needs no reset: nothing is read until a pointer says it is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
        end
    end

    assign o_full   = r_full;
    assign o_nempty = r_nempty;
    assign o_head   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_count  = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/axi4_wr_burst_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_wr_burst_tracker
//  Description : AXI4 write-path burst tracker. Queues AWLEN for every accepted
//                write address, holds the W channel until an address is
//                queued, counts beats of the head burst, regenerates WLAST
//                and flags master WLAST that disagrees with the queued length.
//  Ports       : io_clk, io_rst (async, active-high),
//                bus (slave modport): gated AW/W handshakes, io_wlast_o,
//                io_outstanding, io_err_wlast
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_wr_burst_tracker
    import axi4_wr_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int LEN_W    = c_LEN_W_DEF,
    parameter bit CHECK_EN = 1'b1
) (
    input  wire logic              io_clk,
    input  wire logic              io_rst,
    axi4_wr_burst_tracker_if.slave bus
);

    localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

    logic                      w_full;
    logic                      w_nempty;
    logic [LEN_W-1:0]          w_head;
    logic [OCC_W(DEPTH)-1:0]   w_count;

    logic                      w_awvalid_o;
    logic                      w_awready_o;
    logic                      w_wvalid_o;
    logic                      w_wready_o;
    logic                      w_push;
    logic                      w_beat;
    logic                      w_last;
    logic                      w_pop;
    logic                      w_err;

    logic [LEN_W-1:0]          r_beat_cnt;

    // The flags come from registered FIFO state, so an address accepted this
    // cycle cannot open the W gate until the next one.
    assign w_awvalid_o = bus.io_awvalid & ~w_full;
    assign w_awready_o = bus.io_awready & ~w_full;
    assign w_wvalid_o  = bus.io_wvalid  & w_nempty;
    assign w_wready_o  = bus.io_wready  & w_nempty;

    assign w_push      = w_awvalid_o & w_awready_o;
    assign w_beat      = w_wvalid_o  & w_wready_o;
    assign w_last      = w_nempty & (r_beat_cnt == w_head);
    assign w_pop       = w_beat & w_last;

    axi4_len_fifo #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_len_fifo (
        .clk      (io_clk),
        .rst      (io_rst),
        .i_wr     (w_push),
        .i_din    (bus.io_awlen),
        .i_rd     (w_pop),
        .o_full   (w_full),
        .o_nempty (w_nempty),
        .o_head   (w_head),
        .o_count  (w_count)
    );

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + c_ONE;
        end
    end

    generate
        if (CHECK_EN) begin : g_check
            logic r_err;

            // A mismatch in the same cycle as a clear wins, so no event is lost.
            always_ff @(posedge io_clk or posedge io_rst) begin
                if (io_rst) begin
                    r_err <= 1'b0;
                end else if (w_beat && (bus.io_wlast != w_last)) begin
                    r_err <= 1'b1;
                end else if (bus.io_err_clr) begin
                    r_err <= 1'b0;
                end
            end

            assign w_err = r_err;
        end else begin : g_no_check
            assign w_err = 1'b0;
        end
    endgenerate

    assign bus.io_awvalid_o   = w_awvalid_o;
    assign bus.io_awready_o   = w_awready_o;
    assign bus.io_wvalid_o    = w_wvalid_o;
    assign bus.io_wready_o    = w_wready_o;
    assign bus.io_wlast_o     = w_last;
    assign bus.io_outstanding = w_count;
    assign bus.io_err_wlast   = w_err;

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_burst_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_wr_burst_tracker
//  Description : Self-checking bench for axi4_wr_burst_tracker. A queue of
//                accepted burst lengths plus a beat index and an error flag
//                predict every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi4_wr_burst_tracker;

    localparam int DEPTH = 8;
    localparam int LEN_W = 8;

    logic clk;
    logic rst;

    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference state: lengths of accepted, unfinished bursts (oldest first),
    // beats already transferred of the oldest burst, and the sticky error.
    int   m_q[$];
    int   m_beats;
    bit   m_err;

    axi4_wr_burst_tracker_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    axi4_wr_burst_tracker #(
        .DEPTH    (DEPTH),
        .LEN_W    (LEN_W),
        .CHECK_EN (1'b1)
    ) u_dut (
        .io_clk (clk),
        .io_rst (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // The beat about to be transferred ends the oldest burst when it is beat
    // number AWLEN+1 of that burst.
    function automatic bit exp_last();
        if (m_q.size() == 0) return 1'b0;
        return (m_beats == m_q[0]);
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_beats = 0;
        m_err   = 1'b0;
    endfunction

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic cyc(input bit awv, input bit awr, input int len,
                       input bit wv, input bit wr, input bit wl, input bit clr);
        bit full, has_addr, last, push, beat;
        bus.io_awvalid = awv;
        bus.io_awready = awr;
        bus.io_awlen   = LEN_W'(len);
        bus.io_wvalid  = wv;
        bus.io_wready  = wr;
        bus.io_wlast   = wl;
        bus.io_err_clr = clr;
        #1;
        full     = (m_q.size() == DEPTH);
        has_addr = (m_q.size() != 0);
        last     = exp_last();
        chk("awvalid_o",   bus.io_awvalid_o,   32'(awv && !full));
        chk("awready_o",   bus.io_awready_o,   32'(awr && !full));
        chk("wvalid_o",    bus.io_wvalid_o,    32'(wv && has_addr));
        chk("wready_o",    bus.io_wready_o,    32'(wr && has_addr));
        chk("wlast_o",     bus.io_wlast_o,     32'(last));
        chk("outstanding", bus.io_outstanding, 32'(m_q.size()));
        chk("err_wlast",   bus.io_err_wlast,   32'(m_err));
        push = awv && awr && !full;
        beat = wv && wr && has_addr;
        @(posedge clk);
        if (beat) begin
            if (last) begin
                void'(m_q.pop_front());
                m_beats = 0;
            end else begin
                m_beats++;
            end
        end
        if (push) m_q.push_back(len);
        if (beat && (wl != last)) m_err = 1'b1;
        else if (clr)             m_err = 1'b0;
        @(negedge clk);
    endtask

    // Drain every queued burst with correct WLAST.
    task automatic drain();
        for (int i = 0; i < 200 && m_q.size() != 0; i++) begin
            cyc(0, 0, 0, 1, 1, exp_last(), 0);
        end
        chk("drained", 32'(m_q.size()), 0);
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        bus.io_awvalid = 1'b1;
        bus.io_awready = 1'b1;
        bus.io_awlen   = '0;
        bus.io_wvalid  = 1'b1;
        bus.io_wready  = 1'b1;
        bus.io_wlast   = 1'b0;
        bus.io_err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        // Reset state: AW follows inputs, everything else low.
        chk("rst_awvalid_o",   bus.io_awvalid_o,   1);
        chk("rst_awready_o",   bus.io_awready_o,   1);
        chk("rst_wvalid_o",    bus.io_wvalid_o,    0);
        chk("rst_wready_o",    bus.io_wready_o,    0);
        chk("rst_wlast_o",     bus.io_wlast_o,     0);
        chk("rst_outstanding", bus.io_outstanding, 0);
        chk("rst_err",         bus.io_err_wlast,   0);
        @(negedge clk);
        rst = 1'b0;

        // 1: len=3 burst; W offered alongside the address is held off.
        cyc(1, 1, 3, 1, 1, 0, 0);
        for (int b = 1; b <= 4; b++) cyc(0, 0, 0, 1, 1, b == 4, 0);
        chk("t1_outstanding", bus.io_outstanding, 0);

        // 2: fill to DEPTH with W idle, the ninth address is blocked.
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("t2_full_count", bus.io_outstanding, DEPTH);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // 3: refill, then push and last beat in the same cycle.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 1, 1, 0);
        chk("t3_outstanding", bus.io_outstanding, DEPTH - 1);
        drain();

        // 4: len=1 with early master WLAST; error is sticky until cleared.
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 5: W waits on an empty queue, passes the cycle after AW.
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 2, 1, 1, 0, 0);
        for (int b = 1; b <= 3; b++) cyc(0, 0, 0, 1, 1, b == 3, 0);

        // 6: reset on beat 2 of a len=3 burst flushes everything at once.
        cyc(1, 1, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        bus.io_wvalid = 1'b1;
        bus.io_wready = 1'b1;
        bus.io_wlast  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_outstanding", bus.io_outstanding, 0);
        chk("t6_wvalid_o",    bus.io_wvalid_o,    0);
        chk("t6_wlast_o",     bus.io_wlast_o,     0);
        chk("t6_err",         bus.io_err_wlast,   0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        // Beat counter must restart at zero: len=1 ends on its second beat.
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0);

        // Random traffic with occasional WLAST errors and clears.
        for (int n = 0; n < 3000; n++) begin
            bit awv, awr, wv, wr, wl, clr;
            int len;
            awv = ($urandom_range(0, 3) != 0);
            awr = ($urandom_range(0, 3) != 0);
            len = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) len = $urandom_range(0, 255);
            wv  = ($urandom_range(0, 2) != 0);
            wr  = ($urandom_range(0, 2) != 0);
            wl  = exp_last() ^ ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 19) == 0);
            cyc(awv, awr, len, wv, wr, wl, clr);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
